// File: rtl/branch_resolution_unit.sv
// -----------------------------------------------------------------------------
// branch_resolution_unit
//   Resolves the branch sitting in EX against the prediction made in ID,
//   trains the predictor, redirects fetch and flushes the front of the
//   pipeline on a mispredict, and keeps resolved/mispredicted statistics.
//
// Parameters
//   FLUSH_CYCLES  cycles FLUSH stays high per mispredict (1..15)
//   CNT_WIDTH     width of each saturating statistics counter
//
// Ports
//   CLK             clock, rising edge
//   RESET           asynchronous active-low reset
//   STALL           pipeline hold: freezes capture and resolution
//   ID_BRANCH       branch present in ID this cycle
//   ID_PC           PC of the ID-stage instruction
//   ID_PRED_TAKEN   predictor decision for the ID-stage branch
//   EX_BRANCH_OUT   actual outcome of the EX-stage branch
//   EX_TARGET       computed target of the EX-stage branch
//   UPD_VALID       one-cycle predictor update request
//   UPD_INDEX       predictor table index (PC[4:2] of resolved branch)
//   UPD_TAKEN       actual outcome to train with
//   FLUSH           flush of IF/ID and ID/EX registers
//   REDIRECT_VALID  one-cycle PC reload request
//   REDIRECT_PC     corrected fetch address
//   BRANCH_COUNT    resolved branch count (saturating)
//   MISPRED_COUNT   mispredicted branch count (saturating)
// -----------------------------------------------------------------------------
module branch_resolution_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 STALL,
    input  logic                 ID_BRANCH,
    input  logic [31:0]          ID_PC,
    input  logic                 ID_PRED_TAKEN,
    input  logic                 EX_BRANCH_OUT,
    input  logic [31:0]          EX_TARGET,
    output logic                 UPD_VALID,
    output logic [2:0]           UPD_INDEX,
    output logic                 UPD_TAKEN,
    output logic                 FLUSH,
    output logic                 REDIRECT_VALID,
    output logic [31:0]          REDIRECT_PC,
    output logic [CNT_WIDTH-1:0] BRANCH_COUNT,
    output logic [CNT_WIDTH-1:0] MISPRED_COUNT
);

    localparam int unsigned PC_W  = 32;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned FC_W  = 4;

    localparam logic [FC_W-1:0]      FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    typedef enum logic {
        RUN      = 1'b0,
        FLUSHING = 1'b1
    } state_e;

    state_e               state_q,          state_d;
    logic [FC_W-1:0]      flush_cnt_q,      flush_cnt_d;

    logic                 ex_valid_q,       ex_valid_d;
    logic [PC_W-1:0]      ex_pc_q,          ex_pc_d;
    logic                 ex_pred_q,        ex_pred_d;

    logic                 upd_valid_q,      upd_valid_d;
    logic [IDX_W-1:0]     upd_index_q,      upd_index_d;
    logic                 upd_taken_q,      upd_taken_d;
    logic                 flush_q,          flush_d;
    logic                 redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]      redirect_pc_q,    redirect_pc_d;
    logic [CNT_WIDTH-1:0] branch_cnt_q,     branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q,    mispred_cnt_d;

    logic                 resolve_c;
    logic                 mispredict_c;
    logic [PC_W-1:0]      fallthrough_c;

    // Resolution happens only in RUN with a live, unstalled EX branch
    assign resolve_c     = (state_q == RUN) && ex_valid_q && !STALL;
    assign mispredict_c  = resolve_c && (ex_pred_q != EX_BRANCH_OUT);
    // Natural 32-bit wrap gives 0xFFFFFFFC + 4 = 0
    assign fallthrough_c = ex_pc_q + PC_W'(4);

    // Next-state and registered-output logic
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        ex_valid_d       = ex_valid_q;
        ex_pc_d          = ex_pc_q;
        ex_pred_d        = ex_pred_q;
        upd_valid_d      = 1'b0;
        upd_index_d      = upd_index_q;
        upd_taken_d      = upd_taken_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;
        flush_d          = 1'b0;

        case (state_q)
            RUN: begin
                if (resolve_c) begin
                    upd_valid_d = 1'b1;
                    upd_index_d = ex_pc_q[4:2];
                    upd_taken_d = EX_BRANCH_OUT;
                    if (branch_cnt_q != CNT_MAX) begin
                        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
                    end
                    if (mispredict_c) begin
                        if (mispred_cnt_q != CNT_MAX) begin
                            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
                        end
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = EX_BRANCH_OUT ? EX_TARGET : fallthrough_c;
                        state_d          = FLUSHING;
                        flush_cnt_d      = FLUSH_LOAD;
                    end
                end
                // Resolved branch is consumed by reloading from ID
                if (!STALL) begin
                    ex_valid_d = ID_BRANCH;
                    ex_pc_d    = ID_PC;
                    ex_pred_d  = ID_PRED_TAKEN;
                end
            end
            FLUSHING: begin
                // Wrong-path instructions are dropped; counter ignores STALL
                ex_valid_d = 1'b0;
                if (flush_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                ex_valid_d = 1'b0;
            end
        endcase

        // FLUSH is a registered image of the next state
        flush_d = (state_d == FLUSHING);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q          <= RUN;
            flush_cnt_q      <= '0;
            ex_valid_q       <= 1'b0;
            ex_pc_q          <= '0;
            ex_pred_q        <= 1'b0;
            upd_valid_q      <= 1'b0;
            upd_index_q      <= '0;
            upd_taken_q      <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            ex_valid_q       <= ex_valid_d;
            ex_pc_q          <= ex_pc_d;
            ex_pred_q        <= ex_pred_d;
            upd_valid_q      <= upd_valid_d;
            upd_index_q      <= upd_index_d;
            upd_taken_q      <= upd_taken_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign UPD_VALID      = upd_valid_q;
    assign UPD_INDEX      = upd_index_q;
    assign UPD_TAKEN      = upd_taken_q;
    assign FLUSH          = flush_q;
    assign REDIRECT_VALID = redirect_valid_q;
    assign REDIRECT_PC    = redirect_pc_q;
    assign BRANCH_COUNT   = branch_cnt_q;
    assign MISPRED_COUNT  = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolution_unit
//   Two instances share stimulus: default counters and 4-bit counters.
//   A behavioural model tracks the pending EX branch and the number of flush
//   cycles still to be shown; outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_branch_resolution_unit;

    localparam int unsigned FC  = 2;
    localparam int unsigned CW0 = 16;
    localparam int unsigned CW1 = 4;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        ID_BRANCH;
    logic [31:0] ID_PC;
    logic        ID_PRED_TAKEN;
    logic        EX_BRANCH_OUT;
    logic [31:0] EX_TARGET;

    logic           upd_valid0, upd_taken0, flush0, rv0;
    logic [2:0]     upd_index0;
    logic [31:0]    rpc0;
    logic [CW0-1:0] bc0, mc0;

    logic           upd_valid1, upd_taken1, flush1, rv1;
    logic [2:0]     upd_index1;
    logic [31:0]    rpc1;
    logic [CW1-1:0] bc1, mc1;

    branch_resolution_unit #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW0)) dut0 (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .ID_BRANCH(ID_BRANCH),
        .ID_PC(ID_PC), .ID_PRED_TAKEN(ID_PRED_TAKEN),
        .EX_BRANCH_OUT(EX_BRANCH_OUT), .EX_TARGET(EX_TARGET),
        .UPD_VALID(upd_valid0), .UPD_INDEX(upd_index0), .UPD_TAKEN(upd_taken0),
        .FLUSH(flush0), .REDIRECT_VALID(rv0), .REDIRECT_PC(rpc0),
        .BRANCH_COUNT(bc0), .MISPRED_COUNT(mc0)
    );

    branch_resolution_unit #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW1)) dut1 (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .ID_BRANCH(ID_BRANCH),
        .ID_PC(ID_PC), .ID_PRED_TAKEN(ID_PRED_TAKEN),
        .EX_BRANCH_OUT(EX_BRANCH_OUT), .EX_TARGET(EX_TARGET),
        .UPD_VALID(upd_valid1), .UPD_INDEX(upd_index1), .UPD_TAKEN(upd_taken1),
        .FLUSH(flush1), .REDIRECT_VALID(rv1), .REDIRECT_PC(rpc1),
        .BRANCH_COUNT(bc1), .MISPRED_COUNT(mc1)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit started = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        p_valid, p_pred;
    logic [31:0] p_pc;
    int          flush_left;          // FLUSH cycles still to show, incl. current
    logic        m_upd_valid, m_upd_taken, m_rv;
    logic [2:0]  m_upd_index;
    logic [31:0] m_rpc;
    int          m_bc0, m_mc0, m_bc1, m_mc1;

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            p_valid = 0; p_pred = 0; p_pc = 0; flush_left = 0;
            m_upd_valid = 0; m_upd_taken = 0; m_rv = 0; m_upd_index = 0; m_rpc = 0;
            m_bc0 = 0; m_mc0 = 0; m_bc1 = 0; m_mc1 = 0;
        end else begin
            m_upd_valid = 0;
            m_rv        = 0;
            if (flush_left > 0) begin
                flush_left = flush_left - 1;
                p_valid    = 0;
            end else begin
                if (p_valid && !STALL) begin
                    m_upd_valid = 1;
                    m_upd_index = p_pc[4:2];
                    m_upd_taken = EX_BRANCH_OUT;
                    m_bc0 = sat_inc(m_bc0, (1 << CW0) - 1);
                    m_bc1 = sat_inc(m_bc1, (1 << CW1) - 1);
                    if (p_pred != EX_BRANCH_OUT) begin
                        m_mc0 = sat_inc(m_mc0, (1 << CW0) - 1);
                        m_mc1 = sat_inc(m_mc1, (1 << CW1) - 1);
                        m_rv  = 1;
                        m_rpc = EX_BRANCH_OUT ? EX_TARGET : p_pc + 32'd4;
                        flush_left = FC;
                    end
                end
                if (!STALL) begin
                    p_valid = ID_BRANCH;
                    p_pc    = ID_PC;
                    p_pred  = ID_PRED_TAKEN;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge CLK) begin
        if (started) begin
            chk("upd_valid0", 32'(upd_valid0), 32'(m_upd_valid));
            chk("upd_index0", 32'(upd_index0), 32'(m_upd_index));
            chk("upd_taken0", 32'(upd_taken0), 32'(m_upd_taken));
            chk("flush0",     32'(flush0),     32'(flush_left > 0));
            chk("redir_v0",   32'(rv0),        32'(m_rv));
            chk("redir_pc0",  rpc0,            m_rpc);
            chk("bcount0",    32'(bc0),        32'(m_bc0));
            chk("mcount0",    32'(mc0),        32'(m_mc0));
            chk("flush1",     32'(flush1),     32'(flush_left > 0));
            chk("redir_pc1",  rpc1,            m_rpc);
            chk("upd_valid1", 32'(upd_valid1), 32'(m_upd_valid));
            chk("bcount1",    32'(bc1),        32'(m_bc1));
            chk("mcount1",    32'(mc1),        32'(m_mc1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic st, input logic br, input logic [31:0] pc,
                        input logic pr, input logic out, input logic [31:0] tgt);
        STALL = st; ID_BRANCH = br; ID_PC = pc; ID_PRED_TAKEN = pr;
        EX_BRANCH_OUT = out; EX_TARGET = tgt;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        RESET = 1'b1;
        STALL = 0; ID_BRANCH = 0; ID_PC = 0; ID_PRED_TAKEN = 0;
        EX_BRANCH_OUT = 0; EX_TARGET = 0;
        #2 RESET = 1'b0;
        #1;
        chk("rst_upd_valid", 32'(upd_valid0), 32'd0);
        chk("rst_upd_index", 32'(upd_index0), 32'd0);
        chk("rst_flush",     32'(flush0),     32'd0);
        chk("rst_redir_v",   32'(rv0),        32'd0);
        chk("rst_redir_pc",  rpc0,            32'd0);
        chk("rst_bcount",    32'(bc0),        32'd0);
        chk("rst_mcount",    32'(mc0),        32'd0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        started = 1;

        // Correct taken prediction
        step(0, 1, 32'h100, 1, 0, 32'h0);
        step(0, 0, 32'h0,   0, 1, 32'h0);
        chk("ok_upd_valid", 32'(upd_valid0), 32'd1);
        chk("ok_upd_index", 32'(upd_index0), 32'd0);
        chk("ok_upd_taken", 32'(upd_taken0), 32'd1);
        chk("ok_flush",     32'(flush0),     32'd0);
        chk("ok_redir_v",   32'(rv0),        32'd0);
        chk("ok_bcount",    32'(bc0),        32'd1);

        // Not-taken mispredict, fall-through redirect
        step(0, 1, 32'h10C, 1, 0, 32'h0);
        step(0, 0, 32'h0,   0, 0, 32'h0);
        chk("nt_redir_v",   32'(rv0),        32'd1);
        chk("nt_redir_pc",  rpc0,            32'h110);
        chk("nt_upd_index", 32'(upd_index0), 32'd3);
        chk("nt_flush_1",   32'(flush0),     32'd1);
        chk("nt_mcount",    32'(mc0),        32'd1);
        idle();
        chk("nt_flush_2",   32'(flush0),     32'd1);
        chk("nt_redir_v_2", 32'(rv0),        32'd0);
        chk("nt_redir_hold",rpc0,            32'h110);
        idle();
        chk("nt_flush_end", 32'(flush0),     32'd0);

        // Taken mispredict with branches in ID during the flush window
        step(0, 1, 32'h200, 0, 0, 32'h0);
        step(0, 1, 32'h300, 1, 1, 32'h2000);
        chk("tk_redir_pc",  rpc0,            32'h2000);
        chk("tk_bcount",    32'(bc0),        32'd3);
        chk("tk_mcount",    32'(mc0),        32'd2);
        step(0, 1, 32'h304, 0, 0, 32'h0);
        idle();
        chk("tk_flush_end", 32'(flush0),     32'd0);
        idle();
        idle();
        chk("tk_no_resolve",32'(bc0),        32'd3);
        chk("tk_no_upd",    32'(upd_valid0), 32'd0);

        // Stall hold, then PC wrap on fall-through
        step(0, 1, 32'h40, 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'h0, 0, 1, 32'h0);
            chk("st_hold_upd", 32'(upd_valid0), 32'd0);
        end
        step(0, 0, 32'h0, 0, 1, 32'h0);
        chk("st_resolve",   32'(upd_valid0), 32'd1);
        chk("st_bcount",    32'(bc0),        32'd4);
        idle();
        chk("st_once",      32'(upd_valid0), 32'd0);
        step(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0);
        idle();
        chk("wr_redir_v",   32'(rv0),        32'd1);
        chk("wr_redir_pc",  rpc0,            32'h0);
        chk("wr_upd_index", 32'(upd_index0), 32'd7);
        idle();
        idle();

        // Reset in the first FLUSHING cycle, with a branch captured behind it
        step(0, 1, 32'h80, 0, 0, 32'h0);
        step(0, 1, 32'h90, 1, 1, 32'h1234);
        chk("rf_flush_pre", 32'(flush0), 32'd1);
        RESET = 1'b0;
        #1;
        chk("rf_flush",     32'(flush0), 32'd0);
        chk("rf_bcount",    32'(bc0),    32'd0);
        chk("rf_mcount",    32'(mc0),    32'd0);
        chk("rf_redir_pc",  rpc0,        32'd0);
        #1 RESET = 1'b1;
        idle();
        chk("rf_no_pending",32'(upd_valid0), 32'd0);
        step(0, 1, 32'h84, 1, 0, 32'h0);
        step(0, 0, 32'h0,  0, 1, 32'h0);
        chk("rf_run_upd",   32'(upd_valid0), 32'd1);
        chk("rf_run_flush", 32'(flush0),     32'd0);

        // Saturation: 20 mispredicts after a fresh reset
        RESET = 1'b0;
        #1 RESET = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, $urandom & 32'hFFFF_FFFC, 1, 0, 32'h0);
            idle();
            idle();
            idle();
        end
        chk("sat_bcount4",  32'(bc1), 32'd15);
        chk("sat_mcount4",  32'(mc1), 32'd15);
        chk("sat_bcount16", 32'(bc0), 32'd20);
        chk("sat_mcount16", 32'(mc0), 32'd20);

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                RESET = 1'b0;
                #1 RESET = 1'b1;
            end
            step(($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom & 32'hFFFF_FFFC);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles FLUSH stays asserted per mispredict (legal range 1-15).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of each statistics counter.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 Port CLK  input  1  clock; all state is updated on the rising edge.
REQ-005 Port RESET  input  1  asynchronous active-low reset.
REQ-006 Port STALL  input  1  pipeline hold; freezes capture and resolution.
REQ-007 Port ID_BRANCH  input  1  a branch instruction is in the ID stage this cycle.
REQ-008 Port ID_PC  input  32  PC of the ID-stage instruction.
REQ-009 Port ID_PRED_TAKEN  input  1  the predictor's taken/not-taken decision for the ID-stage branch.
REQ-010 Port EX_BRANCH_OUT  input  1  actual branch outcome from the branch control unit, valid for the EX-stage branch.
REQ-011 Port EX_TARGET  input  32  computed branch target (PC + b_imm) for the EX-stage branch.
REQ-012 Port UPD_VALID  output  1  one-cycle pulse requesting a predictor-table update.
REQ-013 Port UPD_INDEX  output  3  predictor-table index, taken as PC[4:2] of the resolved branch.
REQ-014 Port UPD_TAKEN  output  1  actual outcome to train the predictor with.
REQ-015 Port FLUSH  output  1  flush of the IF/ID and ID/EX pipeline registers.
REQ-016 Port REDIRECT_VALID  output  1  one-cycle pulse loading REDIRECT_PC into the PC.
REQ-017 Port REDIRECT_PC  output  32  corrected fetch address.
REQ-018 Port BRANCH_COUNT  output  CNT_WIDTH  number of resolved branches.
REQ-019 Port MISPRED_COUNT  output  CNT_WIDTH  number of mispredicted branches.

Function
REQ-020 Capture register: on each edge with STALL=0 and state RUN, ex_valid SHALL be loaded with ID_BRANCH, and ex_pc and ex_pred SHALL be loaded with ID_PC and ID_PRED_TAKEN.
REQ-021 With STALL=1, ex_valid, ex_pc and ex_pred SHALL hold their values.
REQ-022 Resolution SHALL occur on an edge where ex_valid=1, STALL=0 and state is RUN; the branch is then consumed and ex_valid is reloaded per REQ-020.
REQ-023 On resolution, mispredict SHALL be defined as ex_pred != EX_BRANCH_OUT.
REQ-024 On resolution, the following cycle SHALL show UPD_VALID=1, UPD_INDEX=ex_pc[4:2] and UPD_TAKEN=EX_BRANCH_OUT, with latency of exactly 1 cycle.
REQ-025 On resolution, BRANCH_COUNT SHALL increment by 1 and SHALL saturate at all-ones.
REQ-026 On a mispredict, MISPRED_COUNT SHALL increment by 1 and SHALL saturate at all-ones.
REQ-027 On a mispredict, the next cycle SHALL show REDIRECT_VALID=1 for exactly one cycle.
REQ-028 REDIRECT_PC SHALL equal EX_TARGET when EX_BRANCH_OUT=1, and ex_pc+4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000) otherwise.
REQ-029 The FSM SHALL have two states, RUN and FLUSHING; a mispredict resolution SHALL move RUN to FLUSHING and load the counter with FLUSH_CYCLES-1.
REQ-030 In FLUSHING, FLUSH=1; the counter SHALL decrement every cycle regardless of STALL; when the counter is 0, the state SHALL return to RUN on the next edge.
REQ-031 FLUSH SHALL be asserted for exactly FLUSH_CYCLES consecutive cycles per mispredict.
REQ-032 In FLUSHING, ex_valid SHALL be forced to 0, ID captures SHALL be discarded, and no resolution or update SHALL occur.
REQ-033 A correct prediction SHALL produce an update only, with no FLUSH and no REDIRECT_VALID.
REQ-034 REDIRECT_PC SHALL hold its last value when REDIRECT_VALID=0.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 RESET=0 SHALL immediately force state RUN and clear the flush counter.
REQ-037 RESET=0 SHALL immediately force ex_valid, ex_pred, UPD_VALID, UPD_TAKEN, FLUSH and REDIRECT_VALID to 0.
REQ-038 RESET=0 SHALL immediately force UPD_INDEX=0, REDIRECT_PC=0x00000000, BRANCH_COUNT=0 and MISPRED_COUNT=0.
REQ-039 A reset asserted during FLUSHING SHALL abort the flush; after release the block SHALL start in RUN with no pending branch.

Verification
REQ-040 Correct prediction: ID_PC=0x100, ID_PRED_TAKEN=1, then EX_BRANCH_OUT=1 -> UPD_VALID=1, UPD_INDEX=0, UPD_TAKEN=1, FLUSH=0, REDIRECT_VALID=0, BRANCH_COUNT=1.
REQ-041 Not-taken mispredict: ID_PC=0x10C, pred=1, outcome=0 -> REDIRECT_PC=0x110, UPD_INDEX=3, FLUSH high exactly 2 cycles, MISPRED_COUNT=1.
REQ-042 Taken mispredict with a branch in ID during the flush: pred=0, outcome=1, EX_TARGET=0x2000 -> REDIRECT_PC=0x2000; the ID branch presented in the flush window is never resolved (BRANCH_COUNT +1 only).
REQ-043 Stall hold and PC wrap: ex_valid=1 with STALL=1 for 3 cycles -> no UPD_VALID; after release it resolves once; ID_PC=0xFFFFFFFC, pred=1, outcome=0 -> REDIRECT_PC=0x00000000.
REQ-044 Reset mid-flush: RESET=0 in the first FLUSHING cycle -> FLUSH=0 immediately, counters 0, state RUN after release.
REQ-045 Saturation: CNT_WIDTH=4, 20 mispredicts -> BRANCH_COUNT=MISPRED_COUNT=15.
